// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; head is a register read, flush beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  fetch_entry_t mem_r [QDEPTH];
  logic         push_ok_s;
  logic         pop_ok_s;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= '{pc: 32'h0000_0000, instr: INSTR_NOP};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational ROM and queues {pc, instr}
// towards decode; supports redirect (flush) and debug halt/resume.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;
  logic         push_s;
  logic         pop_s;
  logic         q_full_s;
  logic         q_empty_s;
  fetch_entry_t din_s;
  fetch_entry_t head_s;

  assign imem_addr = pc_r;
  assign if_valid  = !q_empty_s;
  assign if_pc     = head_s.pc;
  assign if_instr  = head_s.instr;
  assign halted    = (state_r == HALTED);
  assign din_s     = '{pc: pc_r, instr: imem_rdata};

  // Handshake, next-pc mux and next-state; redirect discards same-cycle pop/enqueue.
  always_comb begin
    pop_s       = !q_empty_s && if_ready && !redirect_valid;
    push_s      = (state_r == RUN) && !halt_req && !redirect_valid && (!q_full_s || pop_s);
    pc_nxt_s    = pc_r;
    state_nxt_s = state_r;
    if (redirect_valid) begin
      pc_nxt_s = {redirect_pc[31:2], 2'b00};
    end else if (push_s) begin
      pc_nxt_s = pc_r + 32'd4;
    end else begin
      pc_nxt_s = pc_r;
    end
    case (state_r)
      BOOT:    state_nxt_s = halt_req ? HALTED : RUN;
      RUN:     state_nxt_s = halt_req ? HALTED : RUN;
      HALTED:  state_nxt_s = (resume_req && !halt_req && !redirect_valid) ? RUN : HALTED;
      default: state_nxt_s = BOOT;
    endcase
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      state_r <= BOOT;
    end else begin
      pc_r    <= pc_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .flush(redirect_valid),
    .din  (din_s),
    .full (q_full_s),
    .empty(q_empty_s),
    .head (head_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;
  localparam int          NCYC     = 3200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume_req;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume_req(resume_req),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // ROM[i] = i, word addressed.
  assign imem_rdata = {2'b00, imem_addr[31:2]};

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  logic        exp_valid;
  logic        exp_halted;
  logic [31:0] exp_addr;

  // Reference model: mode 0=boot 1=run 2=halted, pc, number of buffered entries.
  int          m_mode;
  logic [31:0] m_pc;
  int          m_cnt;
  int          ready_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop;
    bit enq;
    if (rst) begin
      m_mode = 0;
      m_pc   = RESET_PC;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      pop = (m_cnt > 0) && if_ready && !redirect_valid;
      enq = (m_mode == 1) && !halt_req && !redirect_valid && ((m_cnt < QDEPTH) || pop);
      if (redirect_valid) begin
        m_cnt = 0;
        exp_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        m_cnt = m_cnt - (pop ? 1 : 0) + (enq ? 1 : 0);
        if (enq) begin
          exp_q.push_back('{pc: m_pc, instr: m_pc >> 2});
          m_pc = m_pc + 32'd4;
        end
      end
      case (m_mode)
        0: m_mode = halt_req ? 2 : 1;
        1: m_mode = halt_req ? 2 : 1;
        2: m_mode = (resume_req && !halt_req && !redirect_valid) ? 1 : 2;
        default: m_mode = 0;
      endcase
    end
  endtask

  // Monitor: per-cycle status checks and scoreboard pop on each accepted handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
      chk("halted", {31'b0, halted}, {31'b0, exp_halted});
      chk("imem_addr", imem_addr, exp_addr);
      if (if_valid && if_ready && !redirect_valid && !rst) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_underflow: got handshake pc %h, expected no entry at %0t", if_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("if_pc", if_pc, mon_e.pc);
          chk("if_instr", if_instr, mon_e.instr);
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    halt_req       = 1'b0;
    resume_req     = 1'b0;
    if_ready       = 1'b0;
    m_mode         = 0;
    m_pc           = RESET_PC;
    m_cnt          = 0;
    ready_mode     = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      chk_en     = 1'b1;
      exp_valid  = (m_cnt > 0);
      exp_halted = (m_mode == 2);
      exp_addr   = m_pc;
      if (cyc % 64 == 0) ready_mode = $urandom_range(0, 2);
      case (ready_mode)
        0:       if_ready = 1'b1;
        1:       if_ready = ($urandom_range(0, 1) == 1);
        default: if_ready = ($urandom_range(0, 4) == 0);
      endcase
      rst            = (cyc < 2) || ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'h0000_0103;
        1:       redirect_pc = 32'hFFFF_FFFC;
        2:       redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F);
        default: redirect_pc = $urandom();
      endcase
      if (halt_req) halt_req = ($urandom_range(0, 9) != 0);
      else          halt_req = ($urandom_range(0, 49) == 0);
      resume_req = ($urandom_range(0, 9) == 0);
      if (cyc >= NCYC - 20) begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        resume_req     = 1'b0;
        if_ready       = 1'b1;
      end
      model_step();
    end
    @(negedge clk);
    #1;
    chk("drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
